dec_to_bin_conv: RTL and testbench
==================================

Name: dec_to_bin_conv

Overview:
- Sequential converter from decimal (BCD) digit entry to binary, run on the same single clock as the display logic.
- Sources: switch/button digit entry. Sinks: counters and compare registers that take binary values.
- Algorithm: reverse double-dabble, one bit per clock (shift right, then subtract 3 from any BCD digit >= 8).
- Handshake: start/busy/valid. Range checks: invalid digit and overflow.

Parameters:
- DIGITS, 3: number of BCD input digits, 4 bits each, ones digit in bits [3:0].
- BIN_W, 8: binary result width; also the number of shift iterations.

Ports:
- clk_i  in  1: system clock, rising edge.
- rst_i  in  1: reset, synchronous, active-high.
- start_i  in  1: conversion request, sampled only in IDLE.
- bcd_i  in  4*DIGITS: packed BCD digits {hundreds, tens, ones}.
- bin_o  out  BIN_W: converted binary value, registered.
- valid_o  out  1: one-cycle pulse when bin_o/err_o/ovf_o update.
- busy_o  out  1: high while a conversion is in progress (SHIFT state).
- err_o  out  1: last request had a digit > 9.
- ovf_o  out  1: last request value > 2^BIN_W - 1.

Behaviour:
- Reset (rst_i=1 at a rising edge, wins over all other inputs): state=IDLE; bin_o=0, valid_o=0, busy_o=0, err_o=0, ovf_o=0; internal shift register and iteration counter cleared.
- Reset mid-conversion aborts the conversion. No valid_o pulse for the aborted request.
- States: IDLE, SHIFT, DONE.
- IDLE, start_i=1 at edge N:
  - Latch bcd_i into the BCD register; clear the BIN_W-bit binary register and the counter.
  - Any digit in 0xA..0xF: go to DONE. err_o=1, ovf_o=0, bin_o=0; valid_o pulses high during cycle N+1.
  - Otherwise: go to SHIFT, busy_o=1 from N+1.
- SHIFT, each cycle:
  - Shift {bcd_reg, bin_reg} right 1 bit, then subtract 3 from each BCD digit whose value is >= 8.
  - Increment the counter. After the BIN_W-th iteration go to DONE.
- DONE (entered edge N+BIN_W+1 for valid input):
  - bin_o = bin_reg (low BIN_W bits of the decimal value); err_o=0.
  - ovf_o=1 iff the residual bcd_reg is nonzero.
  - valid_o=1 for exactly this one cycle, busy_o=0. Return to IDLE next edge.
- Latency: valid request to valid_o = BIN_W+1 cycles (9 at defaults). Invalid digit = 1 cycle.
- Holding and ignored inputs:
  - bin_o/err_o/ovf_o hold their values until the next valid_o.
  - start_i in SHIFT or DONE is ignored, not queued.
  - bcd_i changes after the start edge have no effect.
- Back-to-back: start_i held high restarts a conversion on the first IDLE cycle after DONE. Throughput is 1 conversion per BIN_W+2 cycles.
- Arithmetic:
  - Per-digit subtract is 4-bit.
  - Digits never exceed 12 before correction, given valid inputs.
  - No borrow crosses digit boundaries.

Optional Feature:
- Macro: DEC_TO_BIN_SATURATE_EN.
- Defined: on overflow, bin_o = all ones (2^BIN_W - 1); ovf_o still asserted.
- Not defined: on overflow, bin_o = value mod 2^BIN_W (raw bin_reg); ovf_o asserted.
- Error (invalid digit) behaviour is identical in both builds.

Test Plan:
- After reset, bcd_i=0x123, start pulse -> busy_o high for 8 cycles; valid_o pulses 9 cycles after start; bin_o=0x7B; err_o=0, ovf_o=0.
- bcd_i=0x255 -> bin_o=0xFF, ovf_o=0. bcd_i=0x000 -> bin_o=0x00, valid_o still pulses.
- bcd_i=0x999 -> ovf_o=1. bin_o=0xE7 without DEC_TO_BIN_SATURATE_EN, 0xFF with it. Repeat with 0x256 -> 0x00 / 0xFF.
- bcd_i=0x1A3 -> valid_o 1 cycle after start; err_o=1, bin_o=0x00, busy_o never high.
- start_i pulsed again at cycle 3 of SHIFT with bcd_i=0x042 -> ignored; result still from the first request. start_i held high -> second conversion's valid_o exactly 10 cycles after the first.
- rst_i asserted at SHIFT cycle 4 -> next cycle all outputs 0, state IDLE, no valid_o. A fresh start with 0x200 then gives bin_o=0xC8.

Source files
------------

// File: rtl/dec_to_bin_conv.sv
// BCD to binary converter using reverse double-dabble, one bit per clock.
// Define DEC_TO_BIN_SATURATE_EN to clamp overflowing results to all ones.
module dec_to_bin_conv #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   bcd_i,
  output logic [BIN_W-1:0]      bin_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  ovf_o
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [BW-1:0]    bcd_reg;
  logic [BW-1:0]    bcd_nxt;
  logic [BW-1:0]    bcd_sh;
  logic [BW-1:0]    bcd_adj;
  logic [BIN_W-1:0] bin_reg;
  logic [BIN_W-1:0] bin_nxt;
  logic [BIN_W-1:0] bin_sh;
  logic [BIN_W-1:0] fin;
  logic [BIN_W-1:0] res_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             err_nxt;
  logic             ovf_nxt;
  logic             bad;
  logic             over;

  // One iteration: shift right, then pull each digit back into BCD range.
  always_comb begin
    {bcd_sh, bin_sh} = {bcd_reg, bin_reg} >> 1;
    bcd_adj = bcd_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8)
        bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_i[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  // Residual BCD after the last shift is the part above BIN_W bits.
  assign over = |bcd_adj;

`ifdef DEC_TO_BIN_SATURATE_EN
  assign fin = over ? {BIN_W{1'b1}} : bin_sh;
`else
  assign fin = bin_sh;
`endif

  always_comb begin
    state_nxt = state;
    bcd_nxt   = bcd_reg;
    bin_nxt   = bin_reg;
    cnt_nxt   = cnt;
    res_nxt   = bin_o;
    err_nxt   = err_o;
    ovf_nxt   = ovf_o;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          bcd_nxt = bcd_i;
          bin_nxt = '0;
          cnt_nxt = '0;
          if (bad) begin
            state_nxt = DONE;
            res_nxt   = '0;
            err_nxt   = 1'b1;
            ovf_nxt   = 1'b0;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_nxt = bcd_adj;
        bin_nxt = bin_sh;
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST) begin
          state_nxt = DONE;
          res_nxt   = fin;
          err_nxt   = 1'b0;
          ovf_nxt   = over;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_o   <= '0;
      err_o   <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bcd_reg <= bcd_nxt;
      bin_reg <= bin_nxt;
      cnt     <= cnt_nxt;
      bin_o   <= res_nxt;
      err_o   <= err_nxt;
      ovf_o   <= ovf_nxt;
    end
  end

  assign valid_o = (state == DONE);
  assign busy_o  = (state == SHIFT);

endmodule

// File: tb/tb_dec_to_bin_conv.sv
// Randomized self-checking bench for dec_to_bin_conv.
// Reference model works on decimal integer values.
module tb_dec_to_bin_conv;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [4*DIGITS-1:0] bcd;
  logic [BIN_W-1:0]    bin;
  logic                valid;
  logic                busy;
  logic                err;
  logic                ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dec_to_bin_conv #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .bcd_i  (bcd),
    .bin_o  (bin),
    .valid_o(valid),
    .busy_o (busy),
    .err_o  (err),
    .ovf_o  (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input  logic [11:0] b,
                                output logic [7:0]  eb,
                                output logic        ee,
                                output logic        eo);
    int v;
    ee = 1'b0;
    v  = 0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      int dg;
      dg = int'((b >> (4 * d)) & 12'hF);
      if (dg > 9) ee = 1'b1;
      v = v * 10 + dg;
    end
    if (ee) begin
      eb = 8'h00;
      eo = 1'b0;
    end else begin
      eo = (v > 255);
      eb = 8'(v % 256);
`ifdef DEC_TO_BIN_SATURATE_EN
      if (eo) eb = 8'hFF;
`endif
    end
  endfunction

  // Called #1 after an edge with the DUT idle; returns the same way.
  task automatic convert(input logic [11:0] b,
                         input string tag,
                         input int poke);
    logic [7:0] eb;
    logic       ee;
    logic       eo;
    int         k;
    int         nb;
    model(b, eb, ee, eo);
    start = 1'b1;
    bcd   = b;
    @(posedge clk); #1;
    start = 1'b0;
    bcd   = 12'($urandom);
    k  = 1;
    nb = 0;
    while (!valid && k < 40) begin
      if (busy) nb++;
      if (k == poke) begin
        start = 1'b1;
        bcd   = 12'h042;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk({tag, " lat"}, k, ee ? 1 : BIN_W + 1);
    chk({tag, " busy"}, nb, ee ? 0 : BIN_W);
    chk({tag, " bin"}, bin, eb);
    chk({tag, " err"}, err, ee);
    chk({tag, " ovf"}, ovf, eo);
    @(posedge clk); #1;
    chk({tag, " pulse"}, valid, 0);
    chk({tag, " hold"}, bin, eb);
  endtask

  initial begin
    int k;
    int t1;
    int t2;
    int nv;
    logic [11:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    bcd   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst bin", bin, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    convert(12'h123, "c123", 0);
    convert(12'h255, "c255", 0);
    convert(12'h000, "c000", 0);
    convert(12'h999, "c999", 0);
    convert(12'h256, "c256", 0);
    convert(12'h1A3, "c1a3", 0);
    convert(12'h123, "poke", 3);

    for (int n = 0; n < 40; n++) begin
      rb = '0;
      for (int d = 0; d < DIGITS; d++) begin
        int dg;
        if ($urandom_range(0, 7) == 0)
          dg = int'($urandom_range(10, 15));
        else
          dg = int'($urandom_range(0, 9));
        rb = rb | (12'(dg) << (4 * d));
      end
      convert(rb, "rand", 0);
    end

    convert(12'h999, "pre", 0);
    start = 1'b1;
    bcd   = 12'h123;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort bin", bin, 0);
    chk("abort valid", valid, 0);
    chk("abort busy", busy, 0);
    chk("abort err", err, 0);
    chk("abort ovf", ovf, 0);
    nv = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    chk("abort novalid", nv, 0);
    convert(12'h200, "c200", 0);

    start = 1'b1;
    bcd   = 12'h123;
    k  = 0;
    t1 = -1;
    t2 = -1;
    while (t2 < 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (valid) begin
        if (t1 < 0) t1 = k;
        else t2 = k;
      end
    end
    start = 1'b0;
    chk("b2b first", t1, BIN_W + 1);
    chk("b2b gap", t2 - t1, BIN_W + 2);
    chk("b2b bin", bin, 8'h7B);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
